// File: rtl/reg_mem_wb_ctl.sv
// MEM/WB pipeline register: valid/stall/flush control, load alignment and extension,
// pre-muxed writeback data, x0 write suppression and a retired-instruction counter.
module reg_mem_wb_ctl #(
  parameter int RADDR_W  = 5,
  parameter int CNT_W    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               me_valid,
  input  logic [31:0]        me_mem_data,
  input  logic [31:0]        me_alu_o,
  input  logic [RADDR_W-1:0] me_rd,
  input  logic               me_mem2reg,
  input  logic               me_regs_write,
  input  logic [2:0]         me_ld_funct3,
  input  logic               stall,
  input  logic               flush,
  output logic               wb_valid,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               wb_regs_write,
  output logic [31:0]        wb_wdata,
  output logic               wb_mem2reg,
  output logic [CNT_W-1:0]   wb_retire_cnt
);

  // Halfword misalignment traps upstream, so only addr[1] selects the half.
  function automatic logic [31:0] load_ext(input logic [31:0] data,
                                           input logic [1:0]  addr,
                                           input logic [2:0]  funct3);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] res;
    byte_sel = data[{addr, 3'b000} +: 8];
    half_sel = data[{addr[1], 4'b0000} +: 16];
    case (funct3)
      3'd0:    res = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    res = {24'd0, byte_sel};
      3'd1:    res = {{16{half_sel[15]}}, half_sel};
      3'd5:    res = {16'd0, half_sel};
      default: res = data;
    endcase
    return res;
  endfunction

  logic        suppress_x0;
  logic        regs_write_q;
  logic [31:0] wdata_p0;

  assign suppress_x0  = (ZERO_REG != 0) && (me_rd == '0);
  assign regs_write_q = me_valid & me_regs_write & ~suppress_x0;
  assign wdata_p0     = me_mem2reg ? load_ext(me_mem_data, me_alu_o[1:0], me_ld_funct3)
                                   : me_alu_o;

  // ---- MEM -> WB stage boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_regs_write <= 1'b0;
      wb_wdata      <= '0;
      wb_mem2reg    <= 1'b0;
      wb_retire_cnt <= '0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_regs_write <= 1'b0;
      wb_wdata      <= '0;
      wb_mem2reg    <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= me_valid;
      wb_rd         <= me_rd;
      wb_regs_write <= regs_write_q;
      wb_wdata      <= wdata_p0;
      wb_mem2reg    <= me_mem2reg & me_valid;
      if (me_valid)
        wb_retire_cnt <= wb_retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_mem_wb_ctl.sv
// Bench for reg_mem_wb_ctl: two instances (x0 suppression with 8-bit counter, and
// rd 0 ordinary with 32-bit counter) against a behavioural model, plus literal checks.
module tb_reg_mem_wb_ctl;

  logic        clk;
  logic        rst;
  logic        me_valid;
  logic [31:0] me_mem_data;
  logic [31:0] me_alu_o;
  logic [4:0]  me_rd;
  logic        me_mem2reg;
  logic        me_regs_write;
  logic [2:0]  me_ld_funct3;
  logic        stall;
  logic        flush;

  logic        v0, we0, m2r0, v1, we1, m2r1;
  logic [4:0]  rd0, rd1;
  logic [31:0] wd0, wd1;
  logic [7:0]  cnt0;
  logic [31:0] cnt1;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  reg_mem_wb_ctl #(.RADDR_W(5), .CNT_W(8), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst(rst), .me_valid(me_valid), .me_mem_data(me_mem_data),
    .me_alu_o(me_alu_o), .me_rd(me_rd), .me_mem2reg(me_mem2reg),
    .me_regs_write(me_regs_write), .me_ld_funct3(me_ld_funct3),
    .stall(stall), .flush(flush), .wb_valid(v0), .wb_rd(rd0),
    .wb_regs_write(we0), .wb_wdata(wd0), .wb_mem2reg(m2r0), .wb_retire_cnt(cnt0));

  reg_mem_wb_ctl #(.RADDR_W(5), .CNT_W(32), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst(rst), .me_valid(me_valid), .me_mem_data(me_mem_data),
    .me_alu_o(me_alu_o), .me_rd(me_rd), .me_mem2reg(me_mem2reg),
    .me_regs_write(me_regs_write), .me_ld_funct3(me_ld_funct3),
    .stall(stall), .flush(flush), .wb_valid(v1), .wb_rd(rd1),
    .wb_regs_write(we1), .wb_wdata(wd1), .wb_mem2reg(m2r1), .wb_retire_cnt(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: load result computed with shifts and masks.
  function automatic logic [31:0] model_ext(input logic [31:0] d, input logic [1:0] a,
                                            input logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (int'(a) * 8)) & 32'h0000_00FF;
    h = (d >> (int'(a[1]) * 16)) & 32'h0000_FFFF;
    if (f3 == 3'd0) return b[7] ? (b | 32'hFFFF_FF00) : b;
    if (f3 == 3'd4) return b;
    if (f3 == 3'd1) return h[15] ? (h | 32'hFFFF_0000) : h;
    if (f3 == 3'd5) return h;
    return d;
  endfunction

  logic        m_v, m_m2r, m_we0, m_we1;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic [7:0]  m_cnt0;
  logic [31:0] m_cnt1;

  always @(posedge clk) begin
    if (rst || flush) begin
      m_v <= 1'b0; m_rd <= '0; m_we0 <= 1'b0; m_we1 <= 1'b0; m_wd <= '0; m_m2r <= 1'b0;
      if (rst) begin
        m_cnt0 <= '0;
        m_cnt1 <= '0;
      end
    end else if (!stall) begin
      m_v   <= me_valid;
      m_rd  <= me_rd;
      m_m2r <= me_mem2reg && me_valid;
      m_we0 <= me_valid && me_regs_write && (me_rd != 5'd0);
      m_we1 <= me_valid && me_regs_write;
      m_wd  <= me_mem2reg ? model_ext(me_mem_data, me_alu_o[1:0], me_ld_funct3) : me_alu_o;
      if (me_valid) begin
        m_cnt0 <= 8'((32'(m_cnt0) + 1) % 256);
        m_cnt1 <= m_cnt1 + 32'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid0", 32'(v0), 32'(m_v));     chk("valid1", 32'(v1), 32'(m_v));
      chk("rd0", 32'(rd0), 32'(m_rd));      chk("rd1", 32'(rd1), 32'(m_rd));
      chk("we0", 32'(we0), 32'(m_we0));     chk("we1", 32'(we1), 32'(m_we1));
      chk("wdata0", wd0, m_wd);             chk("wdata1", wd1, m_wd);
      chk("m2r0", 32'(m2r0), 32'(m_m2r));   chk("m2r1", 32'(m2r1), 32'(m_m2r));
      chk("cnt0", 32'(cnt0), 32'(m_cnt0));  chk("cnt1", cnt1, m_cnt1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    me_valid      = 1'($urandom);
    me_mem_data   = $urandom;
    me_alu_o      = $urandom;
    me_rd         = 5'($urandom);
    me_mem2reg    = 1'($urandom);
    me_regs_write = 1'($urandom);
    me_ld_funct3  = 3'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(v0), 32'd0);
    chk({tag, "_rd"}, 32'(rd0), 32'd0);
    chk({tag, "_we"}, 32'(we0), 32'd0);
    chk({tag, "_wdata"}, wd0, 32'd0);
    chk({tag, "_m2r"}, 32'(m2r0), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt0), 32'd0);
  endtask

  logic [2:0]  lf3  [7];
  logic [1:0]  la   [7];
  logic [31:0] lexp [7];
  logic [7:0]  held_cnt;

  initial begin
    lf3  = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd7};
    la   = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
    lexp = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
             32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01};

    // Reset with busy inputs.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    me_valid = 1'b1; me_mem_data = 32'hDEAD_BEEF; me_alu_o = 32'h1357_9BDF;
    me_rd = 5'd9; me_mem2reg = 1'b1; me_regs_write = 1'b1; me_ld_funct3 = 3'd2;
    tick();
    chk_en = 1'b1;
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // ALU writeback.
    me_valid = 1'b1; me_regs_write = 1'b1; me_rd = 5'd7; me_mem2reg = 1'b0;
    me_alu_o = 32'h1234_5678;
    tick();
    chk("alu_wdata", wd0, 32'h1234_5678);
    chk("alu_rd", 32'(rd0), 32'd7);
    chk("alu_we", 32'(we0), 32'd1);
    chk("alu_cnt", 32'(cnt0), 32'd1);

    // Load extension table.
    me_mem_data = 32'h80FF_7F01; me_mem2reg = 1'b1;
    for (int i = 0; i < 7; i++) begin
      me_ld_funct3 = lf3[i];
      me_alu_o     = {30'h1000_0000, la[i]};
      tick();
      chk($sformatf("load_%0d", i), wd0, lexp[i]);
    end

    // x0 write suppression.
    me_rd = 5'd0; me_regs_write = 1'b1; me_valid = 1'b1; me_mem2reg = 1'b0;
    tick();
    chk("x0_we_z1", 32'(we0), 32'd0);
    chk("x0_valid_z1", 32'(v0), 32'd1);
    chk("x0_we_z0", 32'(we1), 32'd1);

    // Stall holds everything while inputs change.
    me_rd = 5'd5; me_alu_o = 32'h0000_0555;
    tick();
    held_cnt = cnt0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      me_valid = 1'b1;
      tick();
      chk("stall_rd", 32'(rd0), 32'd5);
      chk("stall_wdata", wd0, 32'h0000_0555);
      chk("stall_cnt", 32'(cnt0), 32'(held_cnt));
    end

    // Flush beats stall.
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(v0), 32'd0);
    chk("flush_we", 32'(we0), 32'd0);
    chk("flush_cnt", 32'(cnt0), 32'(held_cnt));
    stall = 1'b0;

    // Reset beats flush.
    rst = 1'b1;
    tick();
    chk_zero("rstflush");
    rst = 1'b0; flush = 1'b0;

    // Counter wrap on the 8-bit instance.
    for (int i = 0; i < 255; i++) begin
      rand_in();
      me_valid = 1'b1;
      tick();
    end
    chk("wrap_pre", 32'(cnt0), 32'h0000_00FF);
    rand_in();
    me_valid = 1'b1;
    tick();
    chk("wrap_cnt0", 32'(cnt0), 32'h0000_0000);
    chk("wrap_cnt1", cnt1, 32'd256);
    for (int i = 0; i < 10; i++) begin
      rand_in();
      me_valid = 1'b0;
      tick();
    end
    chk("wrap_idle", 32'(cnt0), 32'h0000_0000);

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 600; i++) begin
      rand_in();
      rst   = ($urandom % 60) == 0;
      flush = ($urandom % 10) == 0;
      stall = ($urandom % 5) == 0;
      tick();
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_mem_wb_ctl.md
Name: reg_mem_wb_ctl

Overview:
- Next-generation MEM/WB pipeline register for the 5-stage RV32 core; sits between the data-memory stage and the register-file write port.
- Adds over the plain MEM/WB latch:
  - a valid bit;
  - stall (hold) and flush (bubble) control;
  - load-data byte/halfword alignment and sign/zero extension;
  - a pre-muxed writeback value;
  - x0 write suppression;
  - a retired-instruction counter.
- One-cycle latency; all outputs are registered.

Parameters:
- RADDR_W, 5: register-file address width.
- CNT_W, 32: retired-instruction counter width (legal range 8..64).
- ZERO_REG, 1: when 1, writes to rd==0 are suppressed at capture; when 0, rd 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- me_valid  in  1  the MEM stage holds a real instruction.
- me_mem_data  in  32  raw 32-bit word read from data memory.
- me_alu_o  in  32  ALU result; for loads, the effective address.
- me_rd  in  RADDR_W  destination register.
- me_mem2reg  in  1  1 = writeback from memory, 0 = writeback from the ALU.
- me_regs_write  in  1  instruction writes rd.
- me_ld_funct3  in  3  load funct3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- stall  in  1  hold all WB state.
- flush  in  1  insert a bubble.
- wb_valid  out  1  WB holds a real instruction.
- wb_rd  out  RADDR_W  destination register.
- wb_regs_write  out  1  qualified register-file write enable.
- wb_wdata  out  32  final writeback value.
- wb_mem2reg  out  1  registered copy of me_mem2reg; used by hazard logic.
- wb_retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Event priority, evaluated every rising edge: rst > flush > stall > capture.
- Reset (rst=1):
  - wb_valid=0, wb_rd=0, wb_regs_write=0, wb_wdata=0, wb_mem2reg=0, wb_retire_cnt=0.
  - Reset overrides any in-flight flush or stall.
- Flush (rst=0, flush=1):
  - wb_valid=0, wb_regs_write=0, wb_mem2reg=0, wb_rd=0, wb_wdata=0.
  - Counter unchanged.
  - flush wins over a simultaneous stall.
- Stall (rst=0, flush=0, stall=1):
  - Every output, including the counter, holds its previous value.
  - Inputs are ignored.
- Capture (rst=0, flush=0, stall=0):
  - wb_valid <= me_valid.
  - wb_rd <= me_rd.
  - wb_mem2reg <= me_mem2reg & me_valid.
  - wb_regs_write <= me_valid & me_regs_write & ~(ZERO_REG & (me_rd==0)).
  - wb_wdata <= me_mem2reg ? ld_ext : me_alu_o.
  - wb_wdata is captured even when me_valid=0; consumers qualify it with wb_regs_write.
  - wb_retire_cnt increments by 1 when me_valid=1. It wraps modulo 2^CNT_W: all-ones + 1 -> 0, with no sticky flag.
- ld_ext (combinational, pre-register), with a = me_alu_o[1:0]:
  - LB/LBU: byte = me_mem_data[8*a +: 8]; bits 31:8 = byte[7] (LB) or 0 (LBU).
  - LH/LHU: half = me_mem_data[16*a[1] +: 16]; a[0] is ignored because misalignment is trapped upstream; bits 31:16 = half[15] (LH) or 0 (LHU).
  - LW: me_mem_data unchanged; a is ignored.
  - Reserved funct3 (3, 6, 7): treated as LW.
- Latency: an instruction presented on me_* in cycle N appears on wb_* after the edge ending cycle N, when neither stall nor flush is asserted in that cycle.
- A stall released mid-sequence resumes capture on the first edge with stall=0; no data is lost or duplicated.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive rst=1 for 2 cycles with me_* non-zero and me_valid=1 -> all outputs 0; wb_retire_cnt=0.
- ALU writeback: me_valid=1, me_regs_write=1, me_rd=7, me_mem2reg=0, me_alu_o=0x1234_5678 -> next cycle wb_wdata=0x12345678, wb_rd=7, wb_regs_write=1, counter=1.
- Load extension:
  - me_mem_data=0x80FF_7F01, mem2reg=1, with the following (funct3, addr low bits) pairs:
    - (LB, a=1) -> 0x0000007F;
    - (LB, a=2) -> 0xFFFFFFFF;
    - (LBU, a=3) -> 0x00000080;
    - (LH, a=2) -> 0xFFFF80FF;
    - (LHU, a=0) -> 0x00007F01;
    - (LW) -> 0x80FF7F01;
    - (funct3=7) -> 0x80FF7F01.
  - Each result appears one cycle after issue.
- x0 suppression: me_rd=0, me_regs_write=1, me_valid=1 -> wb_regs_write=0 and wb_valid=1 with ZERO_REG=1; wb_regs_write=1 with ZERO_REG=0.
- Stall/flush:
  - Hold rd=5 in WB, then stall=1 for 3 cycles while inputs change -> outputs frozen, counter unchanged.
  - stall=1 and flush=1 together -> wb_valid=0, wb_regs_write=0.
  - rst=1 together with flush -> full reset values.
- Counter wrap: CNT_W=8, preload 255 retirements, then 1 more -> wb_retire_cnt=0x00; 10 cycles with me_valid=0 -> remains 0.
